led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer_if.sv | 33 +++
 rtl/led_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer_if.sv
// -----------------------------------------------------------------------------
// led_sequencer_if
//   Bus bundle for the LED sequencer: CPU register port plus the LED-register
//   load port.
//
//   i_Addr          2   register select (0=CTRL 1=PATTERN 2=PERIOD 3=FRAME)
//   i_Data         16   CPU write data
//   i_Write_EN      1   CPU write strobe, one cycle per write
//   o_Data         16   combinational readback of the selected register
//   o_LED_Data     16   registered frame {6'b0, frame[9:0]}
//   o_LED_Write_EN  1   registered one-cycle load strobe for the LED register
//
//   slave  : the sequencer side
//   master : the CPU / LED-register side
// -----------------------------------------------------------------------------
interface led_sequencer_if;
  logic [1:0]  i_Addr;
  logic [15:0] i_Data;
  logic        i_Write_EN;
  logic [15:0] o_Data;
  logic [15:0] o_LED_Data;
  logic        o_LED_Write_EN;

  modport slave (
    input  i_Addr, i_Data, i_Write_EN,
    output o_Data, o_LED_Data, o_LED_Write_EN
  );

  modport master (
    output i_Addr, i_Data, i_Write_EN,
    input  o_Data, o_LED_Data, o_LED_Write_EN
  );
endinterface

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//   Drives a 10-bit LED frame into an external LED register. Modes:
//   DIRECT (show PATTERN), BLINK (PATTERN / blank), CHASE (rotate PATTERN),
//   PAUSE (freeze). Steps are paced by a prescaled timebase:
//   one step every (PERIOD+1)*PRESCALE clock cycles.
//
//   Parameters
//     PRESCALE   clock cycles per timebase tick (1..2^20)
//     PERIOD_RST reset value of the PERIOD register
//
//   Ports
//     i_CLK    sole clock, rising edge
//     i_RESET  synchronous, active-high reset
//     bus      led_sequencer_if.slave (CPU registers + LED load port)
//
//   Build option
//     LED_SEQ_BOUNCE_EN  when defined, CHASE bounces between bit 9 and bit 0
//                        instead of rotating.
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter int unsigned PRESCALE   = 50000,
  parameter logic [15:0] PERIOD_RST = 16'd250
) (
  input  logic            i_CLK,
  input  logic            i_RESET,
  led_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    DIRECT,
    BLINK_ON,
    BLINK_OFF,
    CHASE,
    PAUSE
  } state_t;

  localparam logic [1:0]  A_CTRL    = 2'd0;
  localparam logic [1:0]  A_PATTERN = 2'd1;
  localparam logic [1:0]  A_PERIOD  = 2'd2;
  localparam logic [20:0] PRESC_LAST = 21'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic [1:0]  mode_q;
  logic [9:0]  pattern_q;
  logic [15:0] period_q;
  logic [20:0] presc_q;
  logic [15:0] tick_q;
  logic [9:0]  chase_q, chase_d, chase_step;
  logic [9:0]  led_data_q, frame_d;
  logic        led_we_q, load_d;
  logic        do_load;
  logic [9:0]  load_val;
  logic        wr_cfg, tick, step;

`ifdef LED_SEQ_BOUNCE_EN
  logic dir_q, dir_d, dir_step;   // 0 = shifting left, 1 = shifting right
`endif

  // Writes to FRAME are ignored entirely; the other three restart the timebase.
  assign wr_cfg = bus.i_Write_EN && (bus.i_Addr != 2'd3);
  assign tick   = (presc_q == PRESC_LAST);
  // PAUSE freezes the counters, so a stale tick must not count there; a
  // coinciding write wins over the step.
  assign step   = tick && (tick_q == period_q) && !wr_cfg && (state_q != PAUSE);

  // Next chase value for one step.
  always_comb begin
    chase_step = chase_q;
`ifdef LED_SEQ_BOUNCE_EN
    dir_step = dir_q;
    if (chase_q[9] && chase_q[0]) begin
      chase_step = chase_q;               // pinned at both ends: hold
    end else if (!dir_q) begin
      if (chase_q[9]) begin
        dir_step   = 1'b1;
        chase_step = {1'b0, chase_q[9:1]};
      end else begin
        chase_step = {chase_q[8:0], 1'b0};
      end
    end else begin
      if (chase_q[0]) begin
        dir_step   = 1'b0;
        chase_step = {chase_q[8:0], 1'b0};
      end else begin
        chase_step = {1'b0, chase_q[9:1]};
      end
    end
`else
    chase_step = {chase_q[8:0], chase_q[9]};
`endif
  end

  // FSM next-state and frame generation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    chase_d  = chase_q;
    frame_d  = led_data_q;
    load_d   = 1'b0;
    do_load  = 1'b0;
    load_val = pattern_q;
`ifdef LED_SEQ_BOUNCE_EN
    dir_d    = dir_q;
`endif

    if (bus.i_Write_EN && bus.i_Addr == A_CTRL) begin
      unique case (bus.i_Data[1:0])
        2'b00:   state_d = DIRECT;
        2'b01:   state_d = BLINK_ON;
        2'b10:   state_d = CHASE;
        default: state_d = PAUSE;
      endcase
      do_load  = (bus.i_Data[1:0] != 2'b11);
      load_val = pattern_q;
    end else if (bus.i_Write_EN && bus.i_Addr == A_PATTERN) begin
      // New pattern shows immediately unless paused.
      do_load  = (state_q != PAUSE);
      load_val = bus.i_Data[9:0];
      if (state_q == BLINK_OFF) state_d = BLINK_ON;
    end else if (step) begin
      case (state_q)
        BLINK_ON: begin
          state_d = BLINK_OFF;
          frame_d = 10'd0;
          load_d  = 1'b1;
        end
        BLINK_OFF: begin
          state_d = BLINK_ON;
          frame_d = pattern_q;
          load_d  = 1'b1;
        end
        CHASE: begin
          chase_d = chase_step;
          frame_d = chase_step;
          load_d  = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
          dir_d   = dir_step;
`endif
        end
        default: ;
      endcase
    end

    if (do_load) begin
      chase_d = load_val;
      frame_d = load_val;
      load_d  = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
      dir_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_RESET) begin
      state_q    <= DIRECT;
      mode_q     <= 2'b00;
      pattern_q  <= 10'd0;
      period_q   <= PERIOD_RST;
      presc_q    <= 21'd0;
      tick_q     <= 16'd0;
      chase_q    <= 10'd0;
      led_data_q <= 10'd0;
      led_we_q   <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      chase_q  <= chase_d;
      led_we_q <= load_d;
      if (load_d) led_data_q <= frame_d;
`ifdef LED_SEQ_BOUNCE_EN
      dir_q    <= dir_d;
`endif

      if (bus.i_Write_EN) begin
        case (bus.i_Addr)
          A_CTRL:    mode_q    <= bus.i_Data[1:0];
          A_PATTERN: pattern_q <= bus.i_Data[9:0];
          A_PERIOD:  period_q  <= bus.i_Data;
          default: ;
        endcase
      end

      if (wr_cfg) begin
        presc_q <= 21'd0;
        tick_q  <= 16'd0;
      end else if (state_q != PAUSE) begin
        if (tick) begin
          presc_q <= 21'd0;
          tick_q  <= (tick_q == period_q) ? 16'd0 : tick_q + 16'd1;
        end else begin
          presc_q <= presc_q + 21'd1;
        end
      end
    end
  end

  always_comb begin
    case (bus.i_Addr)
      A_CTRL:    bus.o_Data = {14'd0, mode_q};
      A_PATTERN: bus.o_Data = {6'd0, pattern_q};
      A_PERIOD:  bus.o_Data = period_q;
      default:   bus.o_Data = {6'd0, led_data_q};
    endcase
  end

  assign bus.o_LED_Data     = {6'd0, led_data_q};
  assign bus.o_LED_Write_EN = led_we_q;

endmodule
